// File: rtl/cpu_disp_pkg.sv
// Shared constants and types for the CPU board display controller:
// digit count, page-select encoding, hex glyph table and digit-enable helper.
package cpu_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    typedef enum logic [1:0] {
        PAGE_PC  = 2'b00,
        PAGE_RS  = 2'b01,
        PAGE_RT  = 2'b10,
        PAGE_ALU = 2'b11
    } page_e;

    // Digit whose decimal point separates the two displayed bytes.
    localparam digit_idx_t DP_DIGIT = digit_idx_t'(2);

    // Active-low glyphs {g,f,e,d,c,b,a} indexed by hex value; A-F drawn as "A b C d E F".
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    function automatic logic [NUM_DIGITS-1:0] digit_enable(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// Synchronizes and debounces the step push-button into a stable level plus a press pulse.
// STEP_DEBOUNCE_EN selects the counting debouncer; without it the level follows the synchronizer.
module step_debouncer #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic Reset,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    if (DB_CYCLES < 2) begin : g_db_cycles_check
        $error("step_debouncer: DB_CYCLES must be at least 2");
    end

    logic sync1_q;
    logic sync2_q;
    logic stable_q;
    logic stable_d;
    logic prev_q;
    logic pulse_q;

`ifdef STEP_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample agreeing with the accepted level restarts the full interval.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            // Pulse lands in the cycle after the accepted level first reads high.
            pulse_q  <= stable_q & ~prev_q;
        end
    end

    assign level_o = stable_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_display_ctrl.sv
// Board-side CPU companion: debounced step clock (STEP_DEBOUNCE_EN selects the debouncer)
// and a 4-digit multiplexed seven-segment view of a switch-selected pair of CPU buses.
module cpu_display_ctrl
    import cpu_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        btn_step,
    input  logic [1:0]  sw_sel,
    input  logic [31:0] currentIAddr,
    input  logic [31:0] nextIAddr,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] ALU_result,
    input  logic [31:0] DataBus,
    output logic        cpu_clk,
    output logic        step_pulse,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    if (SCAN_DIV < 2) begin : g_scan_div_check
        $error("cpu_display_ctrl: SCAN_DIV must be at least 2");
    end

    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [SCAN_W-1:0]     scan_q;
    logic [SCAN_W-1:0]     scan_d;
    digit_idx_t            idx_q;
    digit_idx_t            idx_d;
    logic [NUM_DIGITS-1:0] an_q;
    logic [NUM_DIGITS-1:0] an_d;
    logic [7:0]            seg_q;
    logic [7:0]            seg_d;
    logic [7:0]            left_byte;
    logic [7:0]            right_byte;
    logic [15:0]           shown_word;
    logic [3:0]            nibble;

    step_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_debouncer (
        .clk     (clk),
        .Reset   (Reset),
        .btn_i   (btn_step),
        .level_o (cpu_clk),
        .pulse_o (step_pulse)
    );

    // Only the low byte of each wide bus is ever displayed.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{currentIAddr[31:8], nextIAddr[31:8], ReadData1[31:8],
                                 ReadData2[31:8], ALU_result[31:8], DataBus[31:8]};

    always_comb begin
        left_byte  = currentIAddr[7:0];
        right_byte = nextIAddr[7:0];
        case (page_e'(sw_sel))
            PAGE_PC: begin
                left_byte  = currentIAddr[7:0];
                right_byte = nextIAddr[7:0];
            end
            PAGE_RS: begin
                left_byte  = {3'b000, rs};
                right_byte = ReadData1[7:0];
            end
            PAGE_RT: begin
                left_byte  = {3'b000, rt};
                right_byte = ReadData2[7:0];
            end
            PAGE_ALU: begin
                left_byte  = ALU_result[7:0];
                right_byte = DataBus[7:0];
            end
            default: begin
                left_byte  = currentIAddr[7:0];
                right_byte = nextIAddr[7:0];
            end
        endcase
    end

    // Digit 0 is the rightmost, so the index walks the word from its low nibble upward.
    always_comb begin
        shown_word = {left_byte, right_byte};
        nibble     = shown_word[{idx_q, 2'b00} +: 4];
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_comb begin
        an_d  = digit_enable(idx_q);
        seg_d = {(idx_q != DP_DIGIT), HEX_SEG[nibble]};
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            scan_q <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            seg_q  <= 8'hFF;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
